// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW hazard detection over a DEPTH-slot shift scoreboard; define HAZARD_FWD_EN for bypass selects
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [REG_ADDR_W-1:0] rs0_if,
    input  logic [REG_ADDR_W-1:0] rs1_if,
    input  logic [REG_ADDR_W-1:0] rd_if,
    input  logic                  we_if,
    input  logic                  load_if,
    input  logic                  flush,
    output logic                  hasHazard,
    output logic [SEL_W-1:0]      fwd_sel0,
    output logic [SEL_W-1:0]      fwd_sel1,
    output logic [CNT_W-1:0]      stall_cnt
);
    logic [DEPTH-1:0]      slot_v;
    logic [DEPTH-1:0]      slot_ld;
    logic [REG_ADDR_W-1:0] slot_rd [DEPTH];
    logic [DEPTH-1:0]      m0, m1;
    logic [SEL_W-1:0]      k0, k1;
    // per-slot source matches; k0/k1 hold (youngest matching slot)+1, 0 when none
    always_comb begin
        m0 = '0;
        m1 = '0;
        k0 = '0;
        k1 = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            m0[k] = slot_v[k] && slot_rd[k] == rs0_if && rs0_if != '0;
            m1[k] = slot_v[k] && slot_rd[k] == rs1_if && rs1_if != '0;
            if (m0[k]) k0 = SEL_W'(k + 1);
            if (m1[k]) k1 = SEL_W'(k + 1);
        end
    end
`ifdef HAZARD_FWD_EN
    logic lu0, lu1;
    assign lu0       = m0[0] && slot_ld[0];
    assign lu1       = m1[0] && slot_ld[0];
    assign hasHazard = if_valid && (lu0 || lu1);
    assign fwd_sel0  = (if_valid && !lu0) ? k0 : '0;
    assign fwd_sel1  = (if_valid && !lu1) ? k1 : '0;
`else
    logic unused_fwd;
    assign unused_fwd = ^{slot_ld, k0, k1};
    assign hasHazard  = if_valid && (|m0 || |m1);
    assign fwd_sel0   = '0;
    assign fwd_sel1   = '0;
`endif
    // valid bits shift toward WB; a stall enters a bubble, flush/reset empties the board
    always_ff @(posedge clk) begin
        if (rst || flush) slot_v <= '0;
        else slot_v <= {slot_v[DEPTH-2:0], if_valid && we_if && rd_if != '0 && !hasHazard};
    end
    // payload shifts alongside; meaningless while its valid bit is clear
    always_ff @(posedge clk) begin
        slot_ld    <= {slot_ld[DEPTH-2:0], load_if};
        slot_rd[0] <= rd_if;
        for (int k = 1; k < DEPTH; k++) slot_rd[k] <= slot_rd[k-1];
    end
    // saturating count of stalled cycles, flush cycles included
    always_ff @(posedge clk) begin
        if (rst) stall_cnt <= '0;
        else if (hasHazard && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed stimulus with queued expectations checked by a monitor
module tb_hazard_scoreboard;
    logic       clk, rst, if_valid, we_if, load_if, flush;
    logic [4:0] rs0_if, rs1_if, rd_if;
    logic       haz, haz_s;
    logic [1:0] f0, f1, f0_s, f1_s;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;
    int checks = 0, failures = 0;

    typedef struct {
        string      name;
        bit         h;
        logic [1:0] f0, f1;
        int         c;
    } exp_t;
    exp_t q[$];

    hazard_scoreboard #(.REG_ADDR_W(5), .DEPTH(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .rs0_if(rs0_if), .rs1_if(rs1_if),
        .rd_if(rd_if), .we_if(we_if), .load_if(load_if), .flush(flush),
        .hasHazard(haz), .fwd_sel0(f0), .fwd_sel1(f1), .stall_cnt(cnt)
    );

    hazard_scoreboard #(.REG_ADDR_W(5), .DEPTH(3), .CNT_W(2)) sat (
        .clk(clk), .rst(rst), .if_valid(if_valid), .rs0_if(rs0_if), .rs1_if(rs1_if),
        .rd_if(rd_if), .we_if(we_if), .load_if(load_if), .flush(flush),
        .hasHazard(haz_s), .fwd_sel0(f0_s), .fwd_sel1(f1_s), .stall_cnt(cnt_s)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%0h want=%0h", n, what, act, exp);
        end
    endtask

    // monitor: outputs are settled mid-cycle, compare against the oldest expectation
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "hasHazard", 32'(haz), 32'(e.h));
            chk(e.name, "fwd_sel0", 32'(f0), 32'(e.f0));
            chk(e.name, "fwd_sel1", 32'(f1), 32'(e.f1));
            chk(e.name, "stall_cnt", 32'(cnt), 32'(e.c));
            chk(e.name, "sat_cnt", 32'(cnt_s), 32'(e.c > 3 ? 3 : e.c));
        end
    end

    task automatic step(input string n, input bit push, input bit v, input int s0, input int s1,
                        input int d, input bit we, input bit ld, input bit fl, input bit r,
                        input bit h, input int e0, input int e1, input int c);
        exp_t e;
        @(posedge clk);
        #1;
        if_valid = v; rs0_if = 5'(s0); rs1_if = 5'(s1); rd_if = 5'(d);
        we_if = we; load_if = ld; flush = fl; rst = r;
        if (push) begin
            e.name = n; e.h = h; e.f0 = 2'(e0); e.f1 = 2'(e1); e.c = c;
            q.push_back(e);
        end
    endtask

    initial begin
        rst = 1; if_valid = 0; rs0_if = 0; rs1_if = 0; rd_if = 0; we_if = 0; load_if = 0; flush = 0;
        //   name           push v  rs0 rs1 rd we ld fl rst  h f0 f1 cnt
        step("rst",          0, 0,  0,  0,  0, 0, 0, 0, 1,  0, 0, 0, 0);
        step("reset",        1, 1,  3,  0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
        step("add_r4",       1, 1,  0,  0,  4, 1, 0, 0, 0,  0, 0, 0, 0);
        step("fwd_s0",       1, 1,  4,  0,  0, 0, 0, 0, 0,  0, 1, 0, 0);
        step("fwd_s1",       1, 1,  4,  0,  0, 0, 0, 0, 0,  0, 2, 0, 0);
        step("fwd_s2",       1, 1,  4,  0,  0, 0, 0, 0, 0,  0, 3, 0, 0);
        step("fwd_none",     1, 1,  4,  0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
        step("load_r4",      1, 1,  0,  0,  4, 1, 1, 0, 0,  0, 0, 0, 0);
        step("load_use",     1, 1,  0,  4,  0, 0, 0, 0, 0,  1, 0, 0, 0);
        step("load_fwd",     1, 1,  0,  4,  0, 0, 0, 0, 0,  0, 0, 2, 1);
        step("wr_r6a",       1, 1,  0,  0,  6, 1, 0, 0, 0,  0, 0, 0, 1);
        step("wr_r6b",       1, 1,  0,  0,  6, 1, 0, 0, 0,  0, 0, 0, 1);
        step("r6_youngest",  1, 1,  6,  6,  0, 0, 0, 0, 0,  0, 1, 1, 1);
        step("invalid_if",   1, 0,  6,  6,  0, 0, 0, 0, 0,  0, 0, 0, 1);
        step("load_r5",      1, 1,  0,  0,  5, 1, 1, 0, 0,  0, 0, 0, 1);
        step("flush_lu",     1, 1,  5,  0,  0, 0, 0, 1, 0,  1, 0, 0, 1);
        step("post_flush",   1, 1,  5,  0,  0, 0, 0, 0, 0,  0, 0, 0, 2);
        step("load_r5b",     1, 1,  0,  0,  5, 1, 1, 0, 0,  0, 0, 0, 2);
        step("rst_mid",      1, 1,  5,  0,  0, 0, 0, 0, 1,  1, 0, 0, 2);
        step("post_rst",     1, 1,  5,  0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
`else
        step("issue_r5",     1, 1,  0,  0,  5, 1, 0, 0, 0,  0, 0, 0, 0);
        step("raw_s0",       1, 1,  0,  5,  0, 0, 0, 0, 0,  1, 0, 0, 0);
        step("raw_s1",       1, 1,  0,  5,  0, 0, 0, 0, 0,  1, 0, 0, 1);
        step("raw_s2",       1, 1,  0,  5,  0, 0, 0, 0, 0,  1, 0, 0, 2);
        step("raw_clear",    1, 1,  0,  5,  0, 0, 0, 0, 0,  0, 0, 0, 3);
        step("r0_writer",    1, 1,  0,  0,  0, 1, 0, 0, 0,  0, 0, 0, 3);
        step("r0_read",      1, 1,  0,  0,  0, 0, 0, 0, 0,  0, 0, 0, 3);
        step("issue_r7",     1, 1,  0,  0,  7, 1, 0, 0, 0,  0, 0, 0, 3);
        step("unrelated",    1, 1,  1,  2,  9, 1, 0, 0, 0,  0, 0, 0, 3);
        step("raw7_s1",      1, 1,  7,  0,  0, 0, 0, 0, 0,  1, 0, 0, 3);
        step("raw7_s2",      1, 1,  7,  0,  0, 0, 0, 0, 0,  1, 0, 0, 4);
        step("raw7_clear",   1, 1,  7,  0,  0, 0, 0, 0, 0,  0, 0, 0, 5);
        step("self_dep",     1, 1,  8,  8,  8, 1, 0, 0, 0,  0, 0, 0, 5);
        step("invalid_if",   1, 0,  8,  0,  0, 0, 0, 0, 0,  0, 0, 0, 5);
        step("flush_hz",     1, 1,  8,  0,  0, 0, 0, 1, 0,  1, 0, 0, 5);
        step("post_flush",   1, 1,  8,  0,  0, 0, 0, 0, 0,  0, 0, 0, 6);
        step("wr_r6a",       1, 1,  0,  0,  6, 1, 0, 0, 0,  0, 0, 0, 6);
        step("wr_r6b",       1, 1,  0,  0,  6, 1, 0, 0, 0,  0, 0, 0, 6);
        step("r6_hz",        1, 1,  6,  0,  0, 0, 0, 0, 0,  1, 0, 0, 6);
        step("rst_mid",      1, 1,  6,  0,  0, 0, 0, 0, 1,  1, 0, 0, 7);
        step("post_rst",     1, 1,  6,  0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
